fp_minmax_reduce: RTL and testbench
===================================

Name: fp_minmax_reduce

Overview:
Parametrised streaming floating-point special-ops unit, the successor to the combinational ABS/NEG/MIN/MAX block in the floating-point ALU.
- Generic exponent/mantissa widths.
- IEEE 754-2008 minNum/maxNum NaN and signed-zero semantics.
- Valid/ready handshake with a registered output.
- Multi-beat reduction mode: running MIN/MAX over a burst delimited by in_last.
- Sits between the ALU operand mux and the result writeback.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width. Word width W = 1+EXP_W+MAN_W.
- CNT_W, 16, width of the reduction element counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_a  in  W  operand A
- in_b  in  W  operand B (ignored by ABS, NEG, RMIN, RMAX)
- in_op  in  3  000 ABS, 001 NEG, 010 MIN, 011 MAX, 100 RMIN, 101 RMAX, 110/111 reserved
- in_last  in  1  final beat of a reduction burst (ignored for element-wise ops)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  W  result word
- out_count  out  CNT_W  beats consumed by the reduction (1 for element-wise)
- out_nan  out  1  at least one NaN operand was seen in this result
- out_invalid  out  1  reserved opcode, or a signalling NaN was seen

Behaviour:
- Reset (async, rst=1): out_valid=0, out_result=0, out_count=0, out_nan=0, out_invalid=0, state=IDLE, accumulator cleared. Reset mid-burst discards the partial reduction.
- Handshake: in_ready = !out_valid || out_ready (combinational). The output register loads on an accepted beat that produces a result. out_* are held stable while out_valid && !out_ready. out_valid clears on a transfer with no new result.
- Element-wise latency: 1 cycle from acceptance to out_valid. Full throughput of 1 beat/cycle when out_ready=1.
- ABS: clear the sign bit. NEG: invert the sign bit. Both are applied to NaNs unchanged (no canonicalisation, no flags).
- MIN/MAX ordering: numeric order, with -0 < +0.
  - Exactly one NaN operand: return the other operand.
  - Both NaN: return canonical qNaN = {0, all-ones exponent, MSB of mantissa=1, rest 0}.
  - out_nan=1 whenever any operand is NaN.
  - out_invalid=1 if any operand is an sNaN (exponent all-ones, mantissa ≠0, mantissa MSB=0).
- Reserved op: result is canonical qNaN, out_invalid=1, latency 1.
- Reduction FSM: states IDLE and ACCUM.
  - IDLE, accepted RMIN/RMAX beat with in_last=0: acc←in_a (NaN stays a "no value" marker), cnt←1, op latched, go to ACCUM. No output.
  - IDLE, accepted with in_last=1: single-element burst. Output in_a (a NaN input outputs canonical qNaN), count=1, stay IDLE.
  - ACCUM, accepted beat: acc←minNum/maxNum(acc, in_a) using the latched op. in_op is ignored. cnt saturates at 2^CNT_W-1.
  - ACCUM, beat with in_last=1: output the combined value and count cnt+1 (saturated), return to IDLE.
  - NaN and sNaN flags are sticky across the burst.
- In ACCUM, a beat whose in_op is element-wise is still treated as a reduction beat; no mixing mid-burst.

Decomposition:
- Shared package fp_pkg:
  - opcode localparams;
  - is_nan/is_snan/canonical_qnan functions parametrised on EXP_W/MAN_W;
  - FSM state encoding.
- One combinational sub-module fp_minmax_cmp. Inputs a, b and sel_max; outputs the result, nan_seen and snan_seen. It is instantiated once and shared by the element-wise MIN/MAX path and the ACCUM update path.

Test Plan:
1. MIN(0x3F800000, 0x40000000) -> 0x3F800000. MAX(0xC0400000, 0x3F800000) -> 0x3F800000. out_valid exactly 1 cycle after acceptance.
2. MIN(0x80000000, 0x00000000) -> 0x80000000. MAX(0x80000000, 0x00000000) -> 0x00000000.
3. MAX(0x7FC00000, 0x40000000) -> 0x40000000 with out_nan=1. MIN(0x7F800001, 0x7FC12345) -> 0x7FC00000 with out_nan=1, out_invalid=1.
4. RMAX burst a = 0x3F800000, 0xC0400000, 0x7FC00000, 0x40000000 (last), with in_op changed to ABS on beat 2 -> single output 0x40000000, out_count=4, out_nan=1. No out_valid on beats 1-3.
5. Back-pressure: out_ready=0 for 3 cycles after result 0x3F800000 -> in_ready=0, output held stable. A queued beat MIN(0x40000000, 0x40400000) is accepted on the out_ready cycle, and 0x40000000 appears on the next cycle.
6. Assert rst mid-RMIN burst after 2 beats -> outputs zero immediately. A following single-beat RMIN(0xC0400000, last) -> 0xC0400000, out_count=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared opcodes, FSM encoding and IEEE-754 field helpers
// for the floating-point min/max/reduce unit.
package fp_pkg;

  localparam logic [2:0] OP_ABS  = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_MIN  = 3'b010;
  localparam logic [2:0] OP_MAX  = 3'b011;
  localparam logic [2:0] OP_RMIN = 3'b100;
  localparam logic [2:0] OP_RMAX = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Helpers work on a 64-bit carrier so any EXP_W/MAN_W pair fits.
  localparam int unsigned FP_MAXW = 64;
  typedef logic [FP_MAXW-1:0] fpw_t;

  function automatic fpw_t low_mask(input int unsigned n);
    return (fpw_t'(1) << n) - fpw_t'(1);
  endfunction

  function automatic logic is_nan(input fpw_t x,
                                  input int unsigned ew,
                                  input int unsigned mw);
    fpw_t e;
    fpw_t m;
    e = (x >> mw) & low_mask(ew);
    m = x & low_mask(mw);
    return (e == low_mask(ew)) && (m != '0);
  endfunction

  function automatic logic is_snan(input fpw_t x,
                                   input int unsigned ew,
                                   input int unsigned mw);
    fpw_t t;
    t = x >> (mw - 1);
    return is_nan(x, ew, mw) && !t[0];
  endfunction

  function automatic fpw_t canonical_qnan(input int unsigned ew,
                                          input int unsigned mw);
    return (low_mask(ew) << mw) | (fpw_t'(1) << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_minmax_cmp.sv
// IEEE 754-2008 minNum/maxNum of two operands, -0 ordered below +0.
// Purely combinational; shared by element-wise and reduction paths.
module fp_minmax_cmp
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel_max,
  output logic [W-1:0] result,
  output logic         nan_seen,
  output logic         snan_seen
);

  localparam logic [W-1:0] QNAN = W'(canonical_qnan(EXP_W, MAN_W));

  logic         a_nan;
  logic         b_nan;
  logic [W-1:0] ka;
  logic [W-1:0] kb;
  logic         a_lt_b;

  assign a_nan = is_nan(fpw_t'(a), EXP_W, MAN_W);
  assign b_nan = is_nan(fpw_t'(b), EXP_W, MAN_W);

  assign nan_seen  = a_nan | b_nan;
  assign snan_seen = is_snan(fpw_t'(a), EXP_W, MAN_W)
                   | is_snan(fpw_t'(b), EXP_W, MAN_W);

  // Sign-magnitude to monotonic unsigned key; -0 maps just below +0.
  assign ka = a[W-1] ? ~a : {1'b1, a[W-2:0]};
  assign kb = b[W-1] ? ~b : {1'b1, b[W-2:0]};
  assign a_lt_b = ka < kb;

  always_comb begin
    result = a;
    unique case (1'b1)
      (a_nan && b_nan):   result = QNAN;
      (a_nan && !b_nan):  result = b;
      (!a_nan && b_nan):  result = a;
      (!a_nan && !b_nan): result = (a_lt_b ^ sel_max) ? a : b;
    endcase
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming FP ABS/NEG/MIN/MAX unit with burst MIN/MAX reduction
// and a registered valid/ready output stage.
module fp_minmax_reduce
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_invalid
);

  localparam logic [W-1:0] QNAN = W'(canonical_qnan(EXP_W, MAN_W));

  state_e             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               max_q, max_d;
  logic               anan_q, anan_d;
  logic               ainv_q, ainv_d;

  logic               valid_q;
  logic [W-1:0]       res_q, res_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               nan_q, nan_d;
  logic               inv_q, inv_d;
  logic               load;

  logic               accept;
  logic               is_red;
  logic               in_accum;
  logic               a_nan;
  logic               a_snan;
  logic [CNT_W-1:0]   cnt_inc;
  logic [W-1:0]       cmp_a;
  logic [W-1:0]       cmp_b;
  logic               cmp_max;
  logic [W-1:0]       cmp_res;
  logic               cmp_nan;
  logic               cmp_snan;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_red   = (in_op == OP_RMIN) || (in_op == OP_RMAX);
  assign in_accum = (state_q == ST_ACCUM);
  assign a_nan    = is_nan(fpw_t'(in_a), EXP_W, MAN_W);
  assign a_snan   = is_snan(fpw_t'(in_a), EXP_W, MAN_W);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // One comparator: accumulator update in ACCUM, operand pair otherwise.
  assign cmp_a   = in_accum ? acc_q : in_a;
  assign cmp_b   = in_accum ? in_a  : in_b;
  assign cmp_max = in_accum ? max_q : in_op[0];

  fp_minmax_cmp #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_cmp (
    .a(cmp_a),
    .b(cmp_b),
    .sel_max(cmp_max),
    .result(cmp_res),
    .nan_seen(cmp_nan),
    .snan_seen(cmp_snan)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      max_q   <= 1'b0;
      anan_q  <= 1'b0;
      ainv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      anan_q  <= anan_d;
      ainv_q  <= ainv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept && is_red && !in_last) state_d = ST_ACCUM;
      ST_ACCUM:
        if (accept && in_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    res_d   = res_q;
    count_d = count_q;
    nan_d   = nan_q;
    inv_d   = inv_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    anan_d  = anan_q;
    ainv_d  = ainv_q;
    if (accept) begin
      if (in_accum) begin
        acc_d  = cmp_res;
        cnt_d  = cnt_inc;
        anan_d = anan_q | cmp_nan;
        ainv_d = ainv_q | cmp_snan;
        if (in_last) begin
          load    = 1'b1;
          res_d   = cmp_res;
          count_d = cnt_inc;
          nan_d   = anan_q | cmp_nan;
          inv_d   = ainv_q | cmp_snan;
        end
      end else begin
        load    = 1'b1;
        count_d = CNT_W'(1);
        nan_d   = 1'b0;
        inv_d   = 1'b0;
        unique case (in_op)
          OP_ABS: res_d = {1'b0, in_a[W-2:0]};
          OP_NEG: res_d = {~in_a[W-1], in_a[W-2:0]};
          OP_MIN, OP_MAX: begin
            res_d = cmp_res;
            nan_d = cmp_nan;
            inv_d = cmp_snan;
          end
          OP_RMIN, OP_RMAX: begin
            acc_d  = in_a;
            cnt_d  = CNT_W'(1);
            max_d  = in_op[0];
            anan_d = a_nan;
            ainv_d = a_snan;
            load   = in_last;
            res_d  = a_nan ? QNAN : in_a;
            nan_d  = a_nan;
            inv_d  = a_snan;
          end
          default: begin
            res_d = QNAN;
            inv_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      count_q <= '0;
      nan_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      res_q   <= res_d;
      count_q <= count_d;
      nan_q   <= nan_d;
      inv_q   <= inv_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = res_q;
  assign out_count   = count_q;
  assign out_nan     = nan_q;
  assign out_invalid = inv_q;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Self-checking bench: vector table, corner sequences and a
// randomized handshake run against a burst-level reference model.
module tb_fp_minmax_reduce;

  localparam logic [31:0] QN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [15:0] out_count;
  logic        out_nan;
  logic        out_invalid;

  int total = 0;
  int bad = 0;

  fp_minmax_reduce #(
    .EXP_W(8),
    .MAN_W(23),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_op(in_op),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_count(out_count),
    .out_nan(out_nan),
    .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [15:0] cnt;
    logic        nan;
    logic        inv;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        nan;
    logic        inv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic m_snan(input logic [31:0] x);
    return m_nan(x) && !x[22];
  endfunction

  // Numeric a < b, treating -0 as below +0.
  function automatic logic less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic logic [31:0] ref_mm(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic mx);
    if (m_nan(a) && m_nan(b)) return QN;
    if (m_nan(a)) return b;
    if (m_nan(b)) return a;
    if (mx) return less(a, b) ? b : a;
    return less(a, b) ? a : b;
  endfunction

  function automatic exp_t ref_elem(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    exp_t e;
    e.cnt = 16'd1;
    e.nan = 1'b0;
    e.inv = 1'b0;
    case (op)
      3'd0: e.res = {1'b0, a[30:0]};
      3'd1: e.res = {~a[31], a[30:0]};
      3'd2, 3'd3: begin
        e.res = ref_mm(a, b, op[0]);
        e.nan = m_nan(a) | m_nan(b);
        e.inv = m_snan(a) | m_snan(b);
      end
      default: begin
        e.res = QN;
        e.inv = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Whole-burst view: fold over the non-NaN elements.
  function automatic exp_t ref_red(input logic [31:0] q[$], input logic mx);
    exp_t e;
    logic have;
    have = 1'b0;
    e.res = QN;
    e.nan = 1'b0;
    e.inv = 1'b0;
    e.cnt = (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
    foreach (q[i]) begin
      e.nan |= m_nan(q[i]);
      e.inv |= m_snan(q[i]);
      if (!m_nan(q[i])) begin
        e.res = have ? ref_mm(e.res, q[i], mx) : q[i];
        have = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_fp();
    case ($urandom % 12)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h3F80_0000;
      3: return 32'hBF80_0000;
      4: return 32'h7F80_0000;
      5: return 32'hFF80_0000;
      6: return 32'h7FC0_0000;
      7: return 32'h7F80_0001;
      8: return 32'hFFC0_0001;
      9: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic last);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_last = last;
  endtask

  vec_t        tv[14];
  exp_t        sbq[$];
  logic [31:0] bq[$];
  logic        inb;
  logic        bmx;
  logic        stall;
  logic [31:0] held;
  exp_t        e;

  initial begin
    tv[0]  = '{3'd2, 32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0};
    tv[1]  = '{3'd3, 32'hC0400000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
    tv[2]  = '{3'd2, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    tv[3]  = '{3'd3, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    tv[4]  = '{3'd3, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b1, 1'b0};
    tv[5]  = '{3'd2, 32'h7F800001, 32'h7FC12345, 32'h7FC00000, 1'b1, 1'b1};
    tv[6]  = '{3'd0, 32'hFFC12345, 32'h00000000, 32'h7FC12345, 1'b0, 1'b0};
    tv[7]  = '{3'd1, 32'h7F800001, 32'h00000000, 32'hFF800001, 1'b0, 1'b0};
    tv[8]  = '{3'd6, 32'h00000001, 32'h00000002, 32'h7FC00000, 1'b0, 1'b1};
    tv[9]  = '{3'd7, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1};
    tv[10] = '{3'd2, 32'h40000000, 32'h7F800001, 32'h40000000, 1'b1, 1'b1};
    tv[11] = '{3'd3, 32'hFF800000, 32'h7F800000, 32'h7F800000, 1'b0, 1'b0};
    tv[12] = '{3'd2, 32'hBF800000, 32'hC0000000, 32'hC0000000, 1'b0, 1'b0};
    tv[13] = '{3'd3, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0};

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_flags", {30'd0, out_nan, out_invalid}, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    foreach (tv[i]) begin
      drive(tv[i].op, tv[i].a, tv[i].b, 1'b0);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_res", i), out_result, tv[i].res);
      chk($sformatf("v%0d_cnt", i), 32'(out_count), 32'd1);
      chk($sformatf("v%0d_nan", i), 32'(out_nan), 32'(tv[i].nan));
      chk($sformatf("v%0d_inv", i), 32'(out_invalid), 32'(tv[i].inv));
    end
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    drive(3'd5, 32'h3F800000, 32'h0, 1'b0);
    tick();
    chk("rb1_valid", 32'(out_valid), 32'd0);
    drive(3'd0, 32'hC0400000, 32'h0, 1'b0);
    tick();
    chk("rb2_valid", 32'(out_valid), 32'd0);
    drive(3'd5, 32'h7FC00000, 32'h0, 1'b0);
    tick();
    chk("rb3_valid", 32'(out_valid), 32'd0);
    drive(3'd5, 32'h40000000, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("rb4_valid", 32'(out_valid), 32'd1);
    chk("rb4_res", out_result, 32'h40000000);
    chk("rb4_cnt", 32'(out_count), 32'd4);
    chk("rb4_nan", 32'(out_nan), 32'd1);
    chk("rb4_inv", 32'(out_invalid), 32'd0);

    drive(3'd2, 32'h3F800000, 32'h40000000, 1'b0);
    tick();
    chk("bp_first", out_result, 32'h3F800000);
    out_ready = 1'b0;
    drive(3'd2, 32'h40000000, 32'h40400000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", out_result, 32'h3F800000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_up", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_res", out_result, 32'h40000000);

    drive(3'd4, 32'h3F800000, 32'h0, 1'b0);
    tick();
    drive(3'd4, 32'hBF800000, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", out_result, 32'd0);
    chk("mrst_count", 32'(out_count), 32'd0);
    tick();
    rst = 1'b0;
    drive(3'd4, 32'hC0400000, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_res", out_result, 32'hC0400000);
    chk("single_cnt", 32'(out_count), 32'd1);

    drive(3'd5, 32'h7F800001, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("single_nan_res", out_result, QN);
    chk("single_nan_flags", {30'd0, out_nan, out_invalid}, 32'd3);
    tick();

    inb = 1'b0;
    bmx = 1'b0;
    stall = 1'b0;
    held = '0;
    for (int c = 0; c < 800; c++) begin
      if (stall) begin
        chk("r_hold_valid", 32'(out_valid), 32'd1);
        chk("r_hold_res", out_result, held);
      end
      in_valid = ($urandom % 4) != 0;
      in_op = 3'($urandom % 8);
      in_a = rnd_fp();
      in_b = rnd_fp();
      in_last = ($urandom % 3) == 0;
      out_ready = ($urandom % 4) != 0;
      #7;
      chk("r_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      stall = out_valid && !out_ready;
      held = out_result;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("r_spurious", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("r_res", out_result, e.res);
          chk("r_cnt", 32'(out_count), 32'(e.cnt));
          chk("r_flags", {30'd0, out_nan, out_invalid}, {30'd0, e.nan, e.inv});
        end
      end
      if (in_valid && in_ready) begin
        if (inb) begin
          bq.push_back(in_a);
          if (in_last) begin
            sbq.push_back(ref_red(bq, bmx));
            inb = 1'b0;
          end
        end else if (in_op == 3'd4 || in_op == 3'd5) begin
          bq.delete();
          bq.push_back(in_a);
          bmx = in_op[0];
          if (in_last) sbq.push_back(ref_red(bq, bmx));
          else inb = 1'b1;
        end else begin
          sbq.push_back(ref_elem(in_op, in_a, in_b));
        end
      end
      tick();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #7;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("d_spurious", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("d_res", out_result, e.res);
          chk("d_cnt", 32'(out_count), 32'(e.cnt));
        end
      end
      tick();
    end
    chk("d_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
